// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit bus master: size encodings, FSM states,
// latched request record and the alignment rule.
package lsu_pkg;

    typedef enum logic [1:0] {
        SEL_NONE = 2'b00,
        SEL_BYTE = 2'b01,
        SEL_HALF = 2'b10,
        SEL_WORD = 2'b11
    } mem_sel_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_RESP = 2'b10
    } state_e;

    localparam logic [3:0] TIMEOUT_MAX = 4'd15;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        mem_sel_e    sel;
        logic        sext;
    } req_t;

    function automatic logic misaligned(input mem_sel_e sel, input logic [1:0] ofs);
        return ((sel == SEL_HALF) && ofs[0]) || ((sel == SEL_WORD) && (ofs != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Byte-lane steering: store byte enables / replicated write data, and load lane
// extraction with sign or zero extension.
module lsu_lane_fmt
    import lsu_pkg::*;
(
    input  mem_sel_e    sel,
    input  logic [1:0]  ofs,
    input  logic        sext,
    input  logic [31:0] wdata,
    input  logic [31:0] mrdata,
    output logic [3:0]  be,
    output logic [31:0] wrep,
    output logic [31:0] ldata
);

    logic [15:0] lane;

    always_comb begin
        be    = 4'b0000;
        wrep  = wdata;
        ldata = mrdata;
        // shift the addressed lane down to bit 0 before extending
        lane  = 16'(mrdata >> {ofs, 3'b000});
        case (sel)
            SEL_BYTE: begin
                be    = 4'b0001 << ofs;
                wrep  = {4{wdata[7:0]}};
                ldata = {{24{sext & lane[7]}}, lane[7:0]};
            end
            SEL_HALF: begin
                be    = 4'b0011 << ofs;
                wrep  = {2{wdata[15:0]}};
                ldata = {{16{sext & lane[15]}}, lane[15:0]};
            end
            SEL_WORD: be = 4'b1111;
            default:  be = 4'b0000;
        endcase
    end

endmodule

// File: rtl/lsu_master.sv
// Single-outstanding data memory bus master: IDLE -> REQ -> RESP handshake with
// misalignment detection and a 15-cycle bus timeout.
module lsu_master
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  mem_sel,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mreq,
    output logic        mwe,
    output logic [31:0] maddr,
    output logic [3:0]  mbe,
    output logic [31:0] mwdata,
    input  logic        mack,
    input  logic [31:0] mrdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        addr_err,
    output logic        bus_err
);

    state_e      state, state_nxt;
    req_t        req_q;
    logic [3:0]  cnt;
    logic        aerr_q, berr_q;
    logic [31:0] rdata_q;
    logic        accept, mis, timeout;
    logic [3:0]  be;
    logic [31:0] wrep, ldata;

    assign accept  = (state == S_IDLE) && start && (MemRead ^ MemWrite) && (mem_sel != 2'b00);
    assign mis     = misaligned(mem_sel_e'(mem_sel), addr[1:0]);
    // counter reaching TIMEOUT_MAX ends the request after exactly 15 REQ cycles
    assign timeout = (state == S_REQ) && !mack && (cnt == TIMEOUT_MAX - 4'd1);

    lsu_lane_fmt u_fmt (
        .sel    (req_q.sel),
        .ofs    (req_q.addr[1:0]),
        .sext   (req_q.sext),
        .wdata  (req_q.wdata),
        .mrdata (mrdata),
        .be     (be),
        .wrep   (wrep),
        .ldata  (ldata)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = mis ? S_RESP : S_REQ;
            S_REQ:   if (mack || timeout) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            req_q   <= '0;
            cnt     <= '0;
            aerr_q  <= 1'b0;
            berr_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req_q  <= '{addr: addr, wdata: wdata, we: MemWrite,
                            sel: mem_sel_e'(mem_sel), sext: sign_ext};
                aerr_q <= mis;
                berr_q <= 1'b0;
                cnt    <= '0;
            end
            if (state == S_REQ) begin
                if (mack) begin
                    if (!req_q.we) rdata_q <= ldata;
                end else begin
                    cnt <= cnt + 4'd1;
                end
                berr_q <= timeout;
            end
        end
    end

    assign mreq     = (state == S_REQ);
    assign mwe      = mreq & req_q.we;
    assign mbe      = mreq ? be : 4'b0000;
    assign maddr    = {req_q.addr[31:2], 2'b00};
    assign mwdata   = wrep;
    assign busy     = (state == S_REQ);
    assign done     = (state == S_RESP);
    assign addr_err = done & aerr_q;
    assign bus_err  = done & berr_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_lsu_master.sv
// Scoreboard bench for lsu_master: directed accesses push expected completions,
// a monitor pops them on done, a responder models the memory and checks bus fields.
module tb_lsu_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, sign_ext = 1'b0;
    logic [1:0]  mem_sel = 2'b00;
    logic [31:0] addr = '0, wdata = '0;
    logic        mreq, mwe, busy, done, addr_err, bus_err;
    logic [31:0] maddr, mwdata, rdata;
    logic [3:0]  mbe;
    logic        mack;
    logic        ack_r = 1'b0, stray = 1'b0;
    logic [31:0] mrdata = '0;

    assign mack = ack_r | stray;

    lsu_master dut (
        .clk(clk), .rst_n(rst_n), .start(start), .MemRead(MemRead), .MemWrite(MemWrite),
        .mem_sel(mem_sel), .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
        .mreq(mreq), .mwe(mwe), .maddr(maddr), .mbe(mbe), .mwdata(mwdata),
        .mack(mack), .mrdata(mrdata), .busy(busy), .done(done), .rdata(rdata),
        .addr_err(addr_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        ae;
        logic        be;
        int          lat;
        int          t0;
    } exp_t;

    exp_t q[$];
    int compared = 0, mismatched = 0;
    int cyc = 0, done_cnt = 0, nreq = 0, rq = 0, ack_delay = -1;
    logic [31:0] exp_addr = '0, exp_wd = '0, resp_data = '0;
    logic [3:0]  exp_be = '0;
    logic        exp_we = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // memory model: acks after ack_delay REQ cycles, checks bus fields every REQ cycle
    always @(negedge clk) begin
        if (mreq) begin
            nreq++;
            chk("maddr", maddr, exp_addr);
            chk("mbe", {28'b0, mbe}, {28'b0, exp_be});
            chk("mwe", {31'b0, mwe}, {31'b0, exp_we});
            chk("busy", {31'b0, busy}, 32'd1);
            if (exp_we) chk("mwdata", mwdata, exp_wd);
            ack_r  = (ack_delay >= 0) && (rq == ack_delay);
            mrdata = ack_r ? resp_data : 32'h5A5A5A5A;
            rq++;
        end else begin
            ack_r = 1'b0;
            rq    = 0;
        end
    end

    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            done_cnt++;
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done: got done=1 expected none at cycle %0d", cyc);
            end else begin
                e = q.pop_front();
                chk("rdata", rdata, e.rd);
                chk("addr_err", {31'b0, addr_err}, {31'b0, e.ae});
                chk("bus_err", {31'b0, bus_err}, {31'b0, e.be});
                chk("latency", 32'(cyc - e.t0), 32'(e.lat));
                chk("busy_at_done", {31'b0, busy}, 32'd0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic run(input string nm, input logic rd, input logic wr, input logic [1:0] sel,
                       input logic sx, input logic [31:0] a, input logic [31:0] wd,
                       input int dly, input logic [31:0] rsp, input int hold,
                       input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erd,
                       input logic eae, input logic eberr, input int elat, input int enreq);
        int d0, k;
        exp_t e;
        exp_addr = {a[31:2], 2'b00}; exp_be = ebe; exp_we = wr; exp_wd = ewd;
        ack_delay = dly; resp_data = rsp; nreq = 0;
        d0 = done_cnt;
        MemRead = rd; MemWrite = wr; mem_sel = sel; sign_ext = sx; addr = a; wdata = wd;
        start = 1'b1;
        e.rd = erd; e.ae = eae; e.be = eberr; e.lat = elat; e.t0 = cyc;
        q.push_back(e);
        tick(hold);
        start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        k = 0;
        while (done_cnt == d0 && k < 40) begin tick(1); k++; end
        if (done_cnt == d0) begin
            compared++;
            mismatched++;
            $display("FAIL %s_done: got no done within 40 cycles expected done", nm);
            q.delete();
        end
        tick(2);
        chk({nm, "_nreq"}, 32'(nreq), 32'(enreq));
    endtask

    initial begin
        int d0;
        tick(2);
        chk("rst_mreq", {31'b0, mreq}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {29'b0, done, addr_err, bus_err}, 32'd0);
        chk("rst_mwe_mbe", {27'b0, mwe, mbe}, 32'd0);
        chk("rst_maddr", maddr, 32'd0);
        chk("rst_mwdata", mwdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        tick(1);
        //  name        rd wr  sel   sx addr          wdata         dly rsp           hold be       ewd           erd           ae bE lat nreq
        run("wst",      0, 1, 2'b11, 0, 32'h104, 32'hDEADBEEF, 0, 32'h0,        1, 4'b1111, 32'hDEADBEEF, 32'h0,        0, 0, 2,  1);
        run("bld_s",    1, 0, 2'b01, 1, 32'h203, 32'h0,        0, 32'h80112233, 1, 4'b1000, 32'h0,        32'hFFFFFF80, 0, 0, 2,  1);
        run("bld_u",    1, 0, 2'b01, 0, 32'h203, 32'h0,        0, 32'h80112233, 1, 4'b1000, 32'h0,        32'h00000080, 0, 0, 2,  1);
        run("hst_dly",  0, 1, 2'b10, 0, 32'h012, 32'h0000ABCD, 3, 32'h0,        1, 4'b1100, 32'hABCDABCD, 32'h00000080, 0, 0, 5,  4);
        run("wld_mis",  1, 0, 2'b11, 0, 32'h102, 32'h0,        0, 32'h0,        1, 4'b1111, 32'h0,        32'h00000080, 1, 0, 1,  0);
        run("hld_s",    1, 0, 2'b10, 1, 32'h022, 32'h0,        0, 32'h80017FFF, 1, 4'b1100, 32'h0,        32'hFFFF8001, 0, 0, 2,  1);
        run("hst_mis",  0, 1, 2'b10, 0, 32'h013, 32'h1234,     0, 32'h0,        1, 4'b1100, 32'h0,        32'hFFFF8001, 1, 0, 1,  0);
        run("bld_b1",   1, 0, 2'b01, 1, 32'h201, 32'h0,        1, 32'h80112233, 1, 4'b0010, 32'h0,        32'h00000022, 0, 0, 3,  2);
        run("wld",      1, 0, 2'b11, 0, 32'h300, 32'h0,        0, 32'h12345678, 1, 4'b1111, 32'h0,        32'h12345678, 0, 0, 2,  1);
        run("wld_tout", 1, 0, 2'b11, 0, 32'h400, 32'h0,       -1, 32'h0,        1, 4'b1111, 32'h0,        32'h12345678, 0, 1, 16, 15);
        run("wld_hold", 1, 0, 2'b11, 0, 32'h104, 32'h0,        0, 32'hCAFEF00D, 3, 4'b1111, 32'h0,        32'hCAFEF00D, 0, 0, 2,  1);
        run("bst_b3",   0, 1, 2'b01, 0, 32'h107, 32'h000000A5, 0, 32'h0,        1, 4'b1000, 32'hA5A5A5A5, 32'hCAFEF00D, 0, 0, 2,  1);

        // starts that must be ignored, plus a stray ack while idle
        nreq = 0; d0 = done_cnt;
        MemRead = 1'b1; mem_sel = 2'b00; start = 1'b1; tick(1);
        MemWrite = 1'b1; mem_sel = 2'b11; tick(1);
        start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; stray = 1'b1; tick(1);
        stray = 1'b0; tick(3);
        chk("ign_nreq", 32'(nreq), 32'd0);
        chk("ign_busy", {31'b0, busy}, 32'd0);
        chk("ign_done_cnt", 32'(done_cnt), 32'(d0));
        chk("ign_rdata", rdata, 32'hCAFEF00D);

        // reset in the middle of a request abandons it without done
        exp_addr = 32'h500; exp_be = 4'b1111; exp_we = 1'b0; ack_delay = -1; nreq = 0;
        d0 = done_cnt;
        MemRead = 1'b1; mem_sel = 2'b11; addr = 32'h500; start = 1'b1; tick(1);
        start = 1'b0; MemRead = 1'b0; tick(2);
        chk("mid_mreq", {31'b0, mreq}, 32'd1);
        rst_n = 1'b0; tick(1);
        chk("rstmid_mreq", {31'b0, mreq}, 32'd0);
        chk("rstmid_busy", {31'b0, busy}, 32'd0);
        chk("rstmid_rdata", rdata, 32'd0);
        rst_n = 1'b1; tick(3);
        chk("rstmid_done_cnt", 32'(done_cnt), 32'(d0));
        run("post_rst", 0, 1, 2'b11, 0, 32'h008, 32'h11223344, 0, 32'h0, 1, 4'b1111, 32'h11223344, 32'h0, 0, 0, 2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 expected earlier finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lsu_master.md
LSU_MASTER -- requirements
Module: lsu_master

Interface
REQ-001 clk  in  1  sole clock; all state SHALL update on rising edge.
REQ-002 rst_n  in  1  reset, synchronous, active-low.
REQ-003 start  in  1  pipeline issues access this cycle.
REQ-004 MemRead  in  1  access is a load.
REQ-005 MemWrite  in  1  access is a store.
REQ-006 mem_sel  in  2  size: 00 none, 01 byte, 10 half, 11 word.
REQ-007 sign_ext  in  1  load result sign-extended when 1, zero-extended when 0.
REQ-008 addr  in  32  byte address (alu_result).
REQ-009 wdata  in  32  store data, right-aligned.
REQ-010 mreq  out  1  bus request to data memory.
REQ-011 mwe  out  1  bus write enable.
REQ-012 maddr  out  32  word address: addr[31:2],2'b00.
REQ-013 mbe  out  4  byte enables; bit0 = lane [7:0] (little-endian).
REQ-014 mwdata  out  32  lane-replicated store data.
REQ-015 mack  in  1  memory accepts/completes request this cycle.
REQ-016 mrdata  in  32  read data, valid in mack cycle.
REQ-017 busy  out  1  access in flight; pipeline stall.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 rdata  out  32  formatted load result.
REQ-020 addr_err  out  1  misaligned access, with done.
REQ-021 bus_err  out  1  timeout, with done.

Function
REQ-022 FSM states IDLE, REQ, RESP; start accepted only in IDLE with MemRead^MemWrite=1 and mem_sel!=00; otherwise ignored.
REQ-023 Accept: latch addr, wdata, MemWrite, mem_sel, sign_ext; go REQ; busy=1 next cycle.
REQ-024 Misalignment (half with addr[0]=1; word with addr[1:0]!=0): go RESP directly, no mreq, done=1 with addr_err=1 next cycle.
REQ-025 REQ: mreq=1; maddr, mwe, mbe, mwdata held stable until mack sampled 1.
REQ-026 mbe: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111; mwdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-027 mack=1 in REQ: capture mrdata (loads), mreq drops next cycle, go RESP.
REQ-028 RESP: done=1 for exactly one cycle, busy=0, return to IDLE; start in RESP cycle ignored.
REQ-029 Load format: select lane by latched addr[1:0]; byte/half extend per sign_ext; word pass-through.
REQ-030 rdata SHALL hold until next load completion; stores leave rdata unchanged.
REQ-031 Timeout counter 4 bits, cleared on entering REQ, increments each REQ cycle without mack; at count 15 without mack: drop mreq, go RESP, bus_err=1, rdata unchanged.
REQ-032 mack outside REQ SHALL be ignored.
REQ-033 Minimum latency: start cycle N, mreq cycle N+1, done cycle N+2.

Reset
REQ-034 rst_n=0 at clock edge: state IDLE, counter 0, mreq, mwe, busy, done, addr_err, bus_err 0, mbe 0, maddr 0, mwdata 0, rdata 0; applies mid-transaction, abandoning it without done.

Structure
REQ-035 Shared package lsu_pkg: mem_sel encodings, FSM state enum, TIMEOUT_MAX=15.
REQ-036 Combinational sub-module lsu_lane_fmt: mbe/mwdata generation and load extraction/extension.

Verification
REQ-037 Word store addr=0x104, wdata=0xDEADBEEF, mack at N+1 -> maddr=0x104, mbe=1111, mwdata=0xDEADBEEF, done at N+2.
REQ-038 Signed byte load addr=0x203, mrdata=0x80112233 -> mbe=1000, rdata=0xFFFFFF80; sign_ext=0 -> 0x00000080.
REQ-039 Half store addr=0x12, wdata=0x0000ABCD, mack delayed 3 cycles -> mbe=1100, mwdata=0xABCDABCD stable 4 cycles, done 1 cycle after mack.
REQ-040 Word load addr=0x102 -> no mreq, done+addr_err=1 at N+1.
REQ-041 Load, mack never asserted -> mreq high 15 cycles, then done+bus_err=1, rdata unchanged.
REQ-042 rst_n=0 during REQ -> next cycle mreq=0, busy=0, no done; new start then completes normally.
